dmem_wait_ctrl: RTL and testbench
=================================

Name: dmem_wait_ctrl

Overview:
- Wait-state controller between the RISC_V MEM-stage data port (Z_ALU_MEM / RS2_MEM / RD_MEM / W_MEM) and the word-addressed DMEM model.
- Translates the byte address to a DMEM word index and inserts a programmable access latency, so the core's stall path is exercised in simulation.
- Signals the core with STALL while busy and pulses READY with registered read data on completion.

Parameters:
- WAIT_CYCLES, 2, idle cycles inserted before the DMEM access (0..15).
- ADDR_BASE, 32'h1001_0000, byte address mapped to DMEM word 0.
- DEPTH_WORDS, 1024, DMEM size in words; addresses at or above it are out of range.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_RD  in  1  core load request (RD_MEM).
- REQ_W  in  1  core store request (W_MEM).
- ADDR  in  32  byte address (Z_ALU_MEM).
- WDATA  in  32  store data (RS2_MEM).
- RDATA  out  32  load data, registered, valid while READY=1.
- READY  out  1  one-cycle completion pulse.
- STALL  out  1  core must hold its MEM stage.
- ERR  out  1  out-of-range or illegal request; valid with READY.
- MEM_ADD  out  30  DMEM word index.
- MEM_DIN  out  32  DMEM write data.
- MEM_RD  out  1  DMEM read strobe.
- MEM_W  out  1  DMEM write strobe.
- MEM_DOUT  in  32  DMEM read data, combinational from MEM_ADD.

Behaviour:
- Reset: all registered outputs are 0 and state is IDLE. STALL is 0 in IDLE with no request.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On REQ_RD or REQ_W, latch ADDR, WDATA and op.
  - Go to WAIT with cnt = WAIT_CYCLES-1, or directly to ACCESS when WAIT_CYCLES=0.
  - STALL = REQ_RD | REQ_W (combinational) in this cycle.
- WAIT: STALL=1. cnt decrements each cycle; at cnt=0 go to ACCESS.
- ACCESS:
  - STALL=1. Assert MEM_RD or MEM_W for exactly this one cycle.
  - MEM_ADD = (addr - ADDR_BASE) >> 2, truncated to 30 bits; MEM_DIN = latched WDATA.
  - On a read, RDATA <= MEM_DOUT at the clock edge. Go to DONE.
- DONE: READY=1 and STALL=0 for one cycle, then IDLE. Requests seen during DONE are ignored; the core re-presents them and they are sampled in IDLE.
- Latency: a request in IDLE at cycle t gives READY at cycle t+WAIT_CYCLES+2.
- Out of range (addr < ADDR_BASE, or word index >= DEPTH_WORDS):
  - No MEM strobe is issued; ACCESS is skipped, going from WAIT or IDLE straight to DONE after the same wait count.
  - ERR=1 and RDATA=0 with READY.
- REQ_RD and REQ_W both high: treated as an illegal request, handled like out of range (ERR=1, no strobe).
- RDATA holds its last value outside DONE. ERR clears when leaving DONE.
- Reset mid-operation: immediate return to IDLE, in-flight access discarded, no strobe issued after RST assertion.
- Counter width is 4 bits; WAIT_CYCLES above 15 is a parameter error, reported with $error at elaboration.

Optional Feature:
- Macro DMEM_WAIT_MISALIGN_CHECK_EN.
- When defined: latched addr[1:0] != 0 is treated as illegal (ERR=1, no strobe, RDATA=0).
- When undefined: addr[1:0] is ignored and the access goes to the truncated word index.

Decomposition:
- Package dmem_wait_pkg holds:
  - state enum (IDLE, WAIT, ACCESS, DONE),
  - the OP_RD / OP_W op encoding,
  - the ADDR_BASE default,
  - a function computing the word index and in-range flag.
- One natural sub-module, dmem_wait_cnt: a loadable 4-bit down-counter with zero flag.

Test Plan:
- WAIT_CYCLES=2; store 32'hDEAD_BEEF to 32'h1001_0008 -> MEM_W high for exactly one cycle with MEM_ADD=2; READY at t+4; ERR=0.
- Load from 32'h1001_0008 after that store -> RDATA=32'hDEAD_BEEF with READY at t+4; STALL high for cycles t..t+3.
- WAIT_CYCLES=0; load from 32'h1001_0000 -> MEM_RD at t+1, READY at t+2.
- Load from 32'h0000_0010 (below base) -> no MEM strobe, READY at t+4 with ERR=1 and RDATA=0.
- RST asserted during WAIT of a store -> outputs 0 immediately and MEM_W never pulses; next request completes normally.
- Store to 32'h1001_0006 with DMEM_WAIT_MISALIGN_CHECK_EN defined -> ERR=1, no MEM_W. Without the macro -> MEM_W with MEM_ADD=1.

Source files
------------

// File: rtl/dmem_wait_pkg.sv
// Shared types and helpers for the DMEM wait-state controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_wait_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_W  = 1'b1
    } op_t;

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h1001_0000;
    localparam int          CNT_W             = 4;

    typedef struct packed {
        logic [29:0] idx;
        logic        in_range;
    } word_loc_t;

    // Word index is the byte offset from base divided by four. An address
    // below base wraps to a huge offset, so it is rejected explicitly.
    function automatic word_loc_t word_loc(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [31:0] off;
        word_loc_t   r;
        off        = addr - base;
        r.idx      = off[31:2];
        r.in_range = (addr >= base) && ({2'b00, off[31:2]} < depth);
        return r;
    endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag; holds at zero instead of wrapping.
// Latency: load and decrement take effect at the next clock edge.
// Backpressure: none; load has priority over decrement.
// Ports: clk, rst (async active-high), load/load_val, dec, zero (cnt_q == 0).
module dmem_wait_cnt
    import dmem_wait_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Wait-state controller between the core MEM-stage data port and the word-addressed DMEM.
// Latency: request sampled in IDLE at cycle t completes with READY at t+WAIT_CYCLES+2.
// Backpressure: STALL holds the core's MEM stage until the READY cycle; requests in DONE are ignored.
//
// Ports: CLK/RST (async active-high); core side REQ_RD, REQ_W, ADDR, WDATA in and
// RDATA, READY, STALL, ERR out; DMEM side MEM_ADD, MEM_DIN, MEM_RD, MEM_W out and
// MEM_DOUT in (combinational from MEM_ADD).
// Build option: define DMEM_WAIT_MISALIGN_CHECK_EN to reject addresses with ADDR[1:0] != 0.
module dmem_wait_ctrl
    import dmem_wait_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_RD,
    input  logic        REQ_W,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        READY,
    output logic        STALL,
    output logic        ERR,
    output logic [29:0] MEM_ADD,
    output logic [31:0] MEM_DIN,
    output logic        MEM_RD,
    output logic        MEM_W,
    input  logic [31:0] MEM_DOUT
);

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_wait_cycles_bad
        $error("dmem_wait_ctrl: WAIT_CYCLES must be in 0..15");
    end

    localparam logic [CNT_W-1:0] WAIT_LD    = WAIT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WAIT_LD_M1 = WAIT_LD - 1'b1;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [29:0] widx_q, widx_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             cnt_dec;
    logic             cnt_zero;

    logic      req;
    logic      misalign;
    logic      illegal;
    word_loc_t loc_in;
    logic      stall_int;

    assign req    = REQ_RD | REQ_W;
    assign loc_in = word_loc(ADDR, ADDR_BASE, DEPTH_WORDS);

`ifdef DMEM_WAIT_MISALIGN_CHECK_EN
    assign misalign = (ADDR[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Both strobes at once has no defined meaning for the DMEM, so it joins
    // the out-of-range case: no strobe, ERR on completion.
    assign illegal = (REQ_RD & REQ_W) | ~loc_in.in_range | misalign;

    dmem_wait_cnt u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        cnt_load   = 1'b0;
        cnt_ld_val = WAIT_LD;
        cnt_dec    = 1'b0;
        stall_int  = 1'b0;
        MEM_RD     = 1'b0;
        MEM_W      = 1'b0;
        READY      = 1'b0;

        case (state_q)
            IDLE: begin
                stall_int = req;
                if (req) begin
                    op_d    = REQ_W ? OP_W : OP_RD;
                    widx_d  = loc_in.idx;
                    wdata_d = WDATA;
                    err_d   = illegal;
                    if (illegal) begin
                        // Error path skips ACCESS, so it waits one extra
                        // cycle to keep the completion latency uniform.
                        cnt_load   = 1'b1;
                        cnt_ld_val = WAIT_LD;
                        state_d    = WAIT;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_load   = 1'b1;
                        cnt_ld_val = WAIT_LD_M1;
                        state_d    = WAIT;
                    end
                end
            end

            WAIT: begin
                stall_int = 1'b1;
                cnt_dec   = 1'b1;
                if (cnt_zero) begin
                    if (err_q) begin
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end

            ACCESS: begin
                stall_int = 1'b1;
                MEM_RD    = (op_q == OP_RD);
                MEM_W     = (op_q == OP_W);
                if (op_q == OP_RD) begin
                    rdata_d = MEM_DOUT;
                end
                state_d = DONE;
            end

            DONE: begin
                READY   = 1'b1;
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            widx_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // STALL is combinational from the request in IDLE; masking with RST keeps
    // every output low for the whole reset window.
    assign STALL   = stall_int & ~RST;
    assign ERR     = (state_q == DONE) & err_q;
    assign RDATA   = rdata_q;
    assign MEM_ADD = (state_q == ACCESS) ? widx_q  : '0;
    assign MEM_DIN = (state_q == ACCESS) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Testbench for dmem_wait_ctrl: WAIT_CYCLES=2 instance driven by directed and random
// transactions against a transaction-level model; WAIT_CYCLES=0 instance for minimum latency.
// Both instances share one DMEM array; only the WAIT_CYCLES=2 instance stores.
module tb_dmem_wait_ctrl;

    localparam int          W2    = 2;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    // WAIT_CYCLES=2 instance
    logic        rd = 0, w = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata, mem_din, mem_dout;
    logic        ready, stall, err, mem_rd, mem_w;
    logic [29:0] mem_add;

    // WAIT_CYCLES=0 instance
    logic        z_rd = 0, z_w = 0;
    logic [31:0] z_addr = 0, z_wdata = 0;
    logic [31:0] z_rdata, z_mem_din, z_mem_dout;
    logic        z_ready, z_stall, z_err, z_mem_rd, z_mem_w;
    logic [29:0] z_mem_add;

    dmem_wait_ctrl #(.WAIT_CYCLES(W2), .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .CLK(clk), .RST(rst), .REQ_RD(rd), .REQ_W(w), .ADDR(addr), .WDATA(wdata),
        .RDATA(rdata), .READY(ready), .STALL(stall), .ERR(err),
        .MEM_ADD(mem_add), .MEM_DIN(mem_din), .MEM_RD(mem_rd), .MEM_W(mem_w),
        .MEM_DOUT(mem_dout)
    );

    dmem_wait_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut_z (
        .CLK(clk), .RST(rst), .REQ_RD(z_rd), .REQ_W(z_w), .ADDR(z_addr), .WDATA(z_wdata),
        .RDATA(z_rdata), .READY(z_ready), .STALL(z_stall), .ERR(z_err),
        .MEM_ADD(z_mem_add), .MEM_DIN(z_mem_din), .MEM_RD(z_mem_rd), .MEM_W(z_mem_w),
        .MEM_DOUT(z_mem_dout)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Environment DMEM: combinational read, write on clock edge.
    logic [31:0] dmem [0:DEPTH-1];
    assign mem_dout   = (mem_add   < 30'(DEPTH)) ? dmem[mem_add[9:0]]   : 32'h0;
    assign z_mem_dout = (z_mem_add < 30'(DEPTH)) ? dmem[z_mem_add[9:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= init_val(i);
        end else if (mem_w && (mem_add < 30'(DEPTH))) begin
            dmem[mem_add[9:0]] <= mem_din;
        end
    end

    // Reference memory: the word contents the core should observe.
    logic [31:0] ref_mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One core transaction on the WAIT_CYCLES=2 instance, checked against the
    // rules: legal iff not both ops, base <= addr, word index < DEPTH
    // (and aligned when the misalign check is built in).
    task automatic txn(input logic t_rd, input logic t_w,
                       input logic [31:0] t_addr, input logic [31:0] t_wd);
        bit          ok;
        longint      idx;
        int          n_w, n_r;
        bit          got;
        logic [31:0] s_add, s_din;
        idx = (longint'(t_addr) - longint'(BASE)) / 4;
        ok  = !(t_rd && t_w) && (t_addr >= BASE) && (idx < DEPTH);
`ifdef DMEM_WAIT_MISALIGN_CHECK_EN
        if (t_addr[1:0] != 2'b00) ok = 0;
`endif
        n_w = 0; n_r = 0; got = 0; s_add = '0; s_din = '0;
        @(negedge clk);
        rd = t_rd; w = t_w; addr = t_addr; wdata = t_wd;
        #1;
        chk("stall_at_request", 32'(stall), 32'd1);
        for (int k = 1; k <= W2 + 8 && !got; k++) begin
            @(negedge clk);
            if (mem_w) begin n_w++; s_add = 32'(mem_add); s_din = mem_din; end
            if (mem_rd) begin n_r++; s_add = 32'(mem_add); end
            if (ready) begin
                got = 1;
                chk("ready_latency", 32'(k), 32'(W2 + 2));
                chk("err_at_ready", 32'(err), ok ? 32'd0 : 32'd1);
                chk("stall_at_ready", 32'(stall), 32'd0);
                if (t_rd && !t_w) chk("load_rdata", rdata, ok ? ref_mem[int'(idx)] : 32'h0);
                rd = 0; w = 0;
            end else begin
                chk("stall_while_busy", 32'(stall), 32'd1);
            end
        end
        rd = 0; w = 0;
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
        chk("mem_w_pulses", 32'(n_w), (ok && t_w) ? 32'd1 : 32'd0);
        chk("mem_rd_pulses", 32'(n_r), (ok && t_rd) ? 32'd1 : 32'd0);
        if (ok) chk("mem_add", s_add, 32'(idx));
        if (ok && t_w) begin
            chk("mem_din", s_din, t_wd);
            ref_mem[int'(idx)] = t_wd;
        end
    endtask

    initial begin
        int          mw_seen;
        int          zs;
        logic [31:0] ra;
        logic        rr, rw;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", {30'd0, mem_rd, mem_w}, 32'd0);
        rst = 0; mem_init = 0;
        @(negedge clk);
        chk("idle_stall_no_req", 32'(stall), 32'd0);

        // Minimum latency: load from base with WAIT_CYCLES=0
        z_rd = 1; z_addr = BASE;
        #1 chk("z_stall_at_request", 32'(z_stall), 32'd1);
        @(negedge clk);
        chk("z_mem_rd_t1", 32'(z_mem_rd), 32'd1);
        chk("z_mem_add_t1", 32'(z_mem_add), 32'd0);
        chk("z_ready_t1", 32'(z_ready), 32'd0);
        @(negedge clk);
        chk("z_ready_t2", 32'(z_ready), 32'd1);
        chk("z_err_t2", 32'(z_err), 32'd0);
        chk("z_rdata_t2", z_rdata, ref_mem[0]);
        z_rd = 0;

        // Below-base load with WAIT_CYCLES=0: no strobe, ERR at t+2
        @(negedge clk);
        z_rd = 1; z_addr = 32'h0000_0010;
        zs = 0;
        @(negedge clk);
        if (z_mem_rd || z_mem_w) zs++;
        chk("z_err_ready_t1", 32'(z_ready), 32'd0);
        @(negedge clk);
        if (z_mem_rd || z_mem_w) zs++;
        chk("z_err_ready_t2", 32'(z_ready), 32'd1);
        chk("z_err_flag", 32'(z_err), 32'd1);
        chk("z_err_rdata", z_rdata, 32'h0);
        chk("z_err_no_strobe", 32'(zs), 32'd0);
        z_rd = 0;

        // Directed cases
        txn(0, 1, 32'h1001_0008, 32'hDEAD_BEEF);
        txn(1, 0, 32'h1001_0008, 32'h0);
        txn(1, 0, 32'h0000_0010, 32'h0);
        txn(1, 0, BASE + 32'(4 * (DEPTH - 1)), 32'h0);
        txn(0, 1, BASE + 32'(4 * DEPTH), 32'h1111_2222);
        txn(1, 1, 32'h1001_0004, 32'h3333_4444);
        txn(0, 1, 32'h1001_0006, 32'hCAFE_F00D);
        txn(1, 0, 32'h1001_0004, 32'h0);

        // Reset in the middle of a store's wait
        @(negedge clk);
        w = 1; addr = BASE + 32'h40; wdata = 32'h1234_5678;
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1; w = 0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_strobes", {30'd0, mem_rd, mem_w}, 32'd0);
        mw_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_w) mw_seen++;
        end
        rst = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_w) mw_seen++;
        end
        chk("rst_no_mem_w", 32'(mw_seen), 32'd0);
        txn(1, 0, BASE + 32'h40, 32'h0);
        txn(0, 1, BASE + 32'h40, 32'h600D_D00D);
        txn(1, 0, BASE + 32'h40, 32'h0);

        // Randomized transactions
        for (int n = 0; n < 160; n++) begin
            int sel_op, sel_a;
            sel_op = $urandom_range(0, 9);
            rr = (sel_op < 4) || (sel_op == 8) || (sel_op == 9);
            rw = (sel_op >= 4) && (sel_op <= 8);
            sel_a = $urandom_range(0, 7);
            case (sel_a)
                4:       ra = BASE + 32'(4 * $urandom_range(DEPTH - 2, DEPTH + 1));
                5:       ra = 32'($urandom_range(0, 32'h1000_FFFF));
                6:       ra = $urandom;
                7:       ra = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                default: ra = BASE + 32'(4 * $urandom_range(0, 63));
            endcase
            txn(rr, rw, ra, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout observed=%0d expected=finish", n_checks);
        $fatal(1, "timeout");
    end

endmodule
